// File: rtl/lake_spec.sv
// lake_spec: stream buffer with affine write/read address generators and writer-ahead dependency checks
// clk, rst_n      : rising-edge clock; asynchronous active-high reset
// flush           : synchronous restart of both iterators, counters and done flags
// config_memory   : static configuration vector (enable, per-port dims/extent/stride/offset, ahead_limit, min_gap)
// port_0*         : write stream (data, valid in; ready out)
// port_1*         : read stream (data, valid out; ready in)
module lake_spec #(
  parameter int DATA_WIDTH         = 16,
  parameter int MEM_DEPTH          = 64,
  parameter int CONFIG_MEMORY_SIZE = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
  input  logic [DATA_WIDTH-1:0]         port_0,
  input  logic                          port_0_valid,
  output logic                          port_0_ready,
  output logic [DATA_WIDTH-1:0]         port_1,
  output logic                          port_1_valid,
  input  logic                          port_1_ready
);
  localparam int AW = $clog2(MEM_DEPTH);
  // unused dims and zero extents both behave as a single iteration
  function automatic logic [47:0] eff_ext(input logic [1:0] dims, input logic [47:0] ext);
    logic [47:0] e;
    e = '0;
    for (int i = 0; i < 3; i++)
      e[16*i +: 16] = (i >= ((dims == 2'd0) ? 1 : int'(dims)) || ext[16*i +: 16] == 16'd0) ? 16'd1 : ext[16*i +: 16];
    return e;
  endfunction
  // odometer step, dim0 innermost; MSB is the carry out of the outermost dim (stream finished)
  function automatic logic [48:0] step(input logic [47:0] idx, input logic [47:0] ext);
    logic [47:0] n;
    logic c;
    n = idx;
    c = 1'b1;
    for (int i = 0; i < 3; i++)
      if (c) begin
        if (idx[16*i +: 16] == ext[16*i +: 16] - 16'd1) n[16*i +: 16] = 16'd0;
        else begin
          n[16*i +: 16] = idx[16*i +: 16] + 16'd1;
          c = 1'b0;
        end
      end
    return {c, n};
  endfunction
  // 16-bit wraparound arithmetic, so unsigned products equal the signed-stride result
  function automatic logic [AW-1:0] addr_of(input logic [47:0] idx, input logic [47:0] str, input logic [15:0] off);
    logic [15:0] a;
    a = off + idx[15:0] * str[15:0] + idx[31:16] * str[31:16] + idx[47:32] * str[47:32];
    return a[AW-1:0];
  endfunction
  logic                  en;
  logic [47:0]           wr_ext, rd_ext, wr_stride, rd_stride;
  logic [15:0]           wr_off, rd_off, ahead, gap;
  logic                  unused_cfg;
  logic [47:0]           wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, wr_step, rd_step;
  logic [31:0]           wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, diff;
  logic                  wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic                  wr_wrap, rd_wrap, wr_fire, rd_fire;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  assign en         = config_memory[0];
  assign wr_ext     = eff_ext(config_memory[2:1], config_memory[50:3]);
  assign wr_stride  = config_memory[98:51];
  assign wr_off     = config_memory[114:99];
  assign rd_ext     = eff_ext(config_memory[116:115], config_memory[164:117]);
  assign rd_stride  = config_memory[212:165];
  assign rd_off     = config_memory[228:213];
  assign ahead      = config_memory[244:229];
  assign gap        = (config_memory[260:245] == 16'd0) ? 16'd1 : config_memory[260:245];
  assign unused_cfg = ^config_memory[CONFIG_MEMORY_SIZE-1:261];
  assign wr_addr = addr_of(wr_idx_q, wr_stride, wr_off);
  assign rd_addr = addr_of(rd_idx_q, rd_stride, rd_off);
  assign {wr_wrap, wr_step} = step(wr_idx_q, wr_ext);
  assign {rd_wrap, rd_step} = step(rd_idx_q, rd_ext);
  // unsigned difference: only wraps once the writer is done, where ready is already masked
  assign diff = wr_cnt_q - rd_cnt_q;
  assign port_0_ready = ~rst_n & en & ~wr_done_q & (diff < {16'd0, ahead});
  assign port_1_valid = ~rst_n & en & ~rd_done_q & ((diff >= {16'd0, gap}) | wr_done_q);
  assign port_1       = port_1_valid ? mem[rd_addr] : '0;
  assign wr_fire = port_0_valid & port_0_ready;
  assign rd_fire = port_1_valid & port_1_ready;
  always_comb begin
    wr_idx_d  = flush ? '0 : wr_fire ? wr_step : wr_idx_q;
    rd_idx_d  = flush ? '0 : rd_fire ? rd_step : rd_idx_q;
    wr_cnt_d  = flush ? '0 : wr_cnt_q + {31'd0, wr_fire};
    rd_cnt_d  = flush ? '0 : rd_cnt_q + {31'd0, rd_fire};
    wr_done_d = ~flush & (wr_done_q | (wr_fire & wr_wrap));
    rd_done_d = ~flush & (rd_done_q | (rd_fire & rd_wrap));
  end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
    end
  always_ff @(posedge clk)
    if (wr_fire & ~flush) mem[wr_addr] <= port_0;
endmodule

// File: tb/tb_lake_spec.sv
// tb_lake_spec: randomized and directed checks of lake_spec against a count/address-list reference model
module tb_lake_spec;
  logic         clk = 0, rst_n = 1, flush = 0;
  logic [511:0] cfg = '0;
  logic [15:0]  p0 = '0, p1;
  logic         p0v = 0, p0r, p1v, p1r = 0;
  int total = 0, bad = 0;
  int en, wd, rdm, wo, ro, ahead, gap;
  int we[3], ws[3], re[3], rs[3];
  int wa[1024], ra[1024];
  int wtot, rtot, wn, rn;
  logic [15:0] mm[64];
  int dut_wr, dut_rd;
  logic [15:0] rdq[$];
  int exp_t[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  always #5 clk = ~clk;
  lake_spec dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .config_memory(cfg),
    .port_0(p0), .port_0_valid(p0v), .port_0_ready(p0r),
    .port_1(p1), .port_1_valid(p1v), .port_1_ready(p1r)
  );
  // address sequence of one port as a plain nested loop, dim0 innermost
  task automatic gen(input bit rd);
    int d, n, e[3], ee[3], s[3], off;
    e = rd ? re : we;
    s = rd ? rs : ws;
    off = rd ? ro : wo;
    d = rd ? rdm : wd;
    if (d == 0) d = 1;
    for (int i = 0; i < 3; i++) ee[i] = (i >= d || e[i] == 0) ? 1 : e[i];
    n = 0;
    for (int i2 = 0; i2 < ee[2]; i2++)
      for (int i1 = 0; i1 < ee[1]; i1++)
        for (int i0 = 0; i0 < ee[0]; i0++) begin
          if (rd) ra[n] = (off + i0 * s[0] + i1 * s[1] + i2 * s[2]) & 63;
          else wa[n] = (off + i0 * s[0] + i1 * s[1] + i2 * s[2]) & 63;
          n++;
        end
    if (rd) rtot = n;
    else wtot = n;
  endtask
  task automatic set_cfg();
    cfg = '0;
    for (int i = 261; i < 512; i++) cfg[i] = 1'($urandom);
    cfg[0] = 1'(en);
    cfg[2:1] = 2'(wd);
    cfg[116:115] = 2'(rdm);
    for (int i = 0; i < 3; i++) begin
      cfg[3 + 16*i +: 16]   = 16'(we[i]);
      cfg[51 + 16*i +: 16]  = 16'(ws[i]);
      cfg[117 + 16*i +: 16] = 16'(re[i]);
      cfg[165 + 16*i +: 16] = 16'(rs[i]);
    end
    cfg[114:99]  = 16'(wo);
    cfg[228:213] = 16'(ro);
    cfg[244:229] = 16'(ahead);
    cfg[260:245] = 16'(gap);
    gen(0);
    gen(1);
  endtask
  task automatic lin(input int ext, input int off, input int ah, input int gp);
    en = 1; wd = 1; rdm = 1; wo = off; ro = off; ahead = ah; gap = gp;
    we = '{ext, 7, 7}; re = '{ext, 3, 3}; ws = '{1, 5, 5}; rs = '{1, 9, 9};
  endtask
  function automatic bit e_rdy();
    return !rst_n && en[0] && wn < wtot && (wn - rn) < ahead;
  endfunction
  function automatic bit e_val();
    return !rst_n && en[0] && rn < rtot && ((wn - rn) >= (gap == 0 ? 1 : gap) || wn == wtot);
  endfunction
  function automatic logic [15:0] e_dat();
    return e_val() ? mm[ra[rn]] : 16'd0;
  endfunction
  always @(posedge clk) begin
    bit wf, rf;
    if (rst_n || flush) begin
      wn = 0;
      rn = 0;
    end else begin
      wf = p0v && e_rdy();
      rf = p1r && e_val();
      if (wf) mm[wa[wn]] = p0;
      wn += int'(wf);
      rn += int'(rf);
    end
  end
  always @(negedge clk) begin
    total += 3;
    if (p0r !== e_rdy()) begin bad++; $display("FAIL ready t=%0t got=%b exp=%b", $time, p0r, e_rdy()); end
    if (p1v !== e_val()) begin bad++; $display("FAIL valid t=%0t got=%b exp=%b", $time, p1v, e_val()); end
    if (p1 !== e_dat()) begin bad++; $display("FAIL data t=%0t got=%h exp=%h", $time, p1, e_dat()); end
    if (!rst_n && !flush && p0v && p0r) dut_wr++;
    if (!rst_n && !flush && p1r && p1v) begin dut_rd++; rdq.push_back(p1); end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic lit(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s got=%0d exp=%0d", nm, got, exp); end
  endtask
  task automatic do_reset();
    rst_n = 1;
    set_cfg();
    tick();
    tick();
    rst_n = 0;
    dut_wr = 0;
    dut_rd = 0;
    rdq.delete();
  endtask
  initial begin
    // FIFO-like backpressure then drain
    lin(1000, 0, 64, 1);
    do_reset();
    p0v = 1;
    p1r = 0;
    for (int k = 0; k < 65; k++) begin p0 = 16'(2 * k); tick(); end
    lit("bp_writes", dut_wr, 64);
    lit("bp_ready", int'(p0r), 0);
    lit("bp_valid", int'(p1v), 1);
    lit("bp_data", int'(p1), 0);
    p1r = 1;
    dut_rd = 0;
    for (int k = 0; k < 200; k++) begin p0 = 16'(2 * (65 + k)); tick(); end
    lit("drain_reads", dut_rd, 200);
    for (int k = 0; k < 4; k++) lit("drain_order", int'(rdq[k]), 2 * k);
    // 2-D transpose
    en = 1; wd = 2; rdm = 2; wo = 0; ro = 0; ahead = 16; gap = 16;
    we = '{4, 4, 9}; ws = '{1, 4, 0}; re = '{4, 4, 9}; rs = '{4, 1, 0};
    do_reset();
    p0v = 1;
    p1r = 1;
    for (int k = 0; k < 40; k++) begin p0 = 16'(k); tick(); end
    lit("tp_count", rdq.size(), 16);
    for (int k = 0; k < 16 && k < rdq.size(); k++) lit("tp_data", int'(rdq[k]), exp_t[k]);
    // completion and flush
    lin(8, 0, 64, 1);
    do_reset();
    for (int k = 0; k < 20; k++) begin p0 = 16'($urandom); tick(); end
    lit("done_wr", dut_wr, 8);
    lit("done_rd", dut_rd, 8);
    lit("done_ready", int'(p0r), 0);
    lit("done_valid", int'(p1v), 0);
    flush = 1;
    tick();
    flush = 0;
    dut_wr = 0;
    for (int k = 0; k < 20; k++) begin p0 = 16'($urandom); tick(); end
    lit("flush_wr", dut_wr, 8);
    // reset mid-stream
    lin(100, 5, 64, 1);
    do_reset();
    p1r = 0;
    for (int k = 0; k < 10; k++) begin p0 = 16'(2 * k); tick(); end
    rst_n = 1;
    #1;
    lit("rst_ready", int'(p0r), 0);
    lit("rst_valid", int'(p1v), 0);
    lit("rst_data", int'(p1), 0);
    tick();
    tick();
    rst_n = 0;
    p0 = 16'hBEEF;
    tick();
    p0v = 0;
    #1;
    lit("rst_first", int'(p1), 'hBEEF);
    // enable low: nothing moves, then counters still start from zero
    lin(100, 0, 64, 1);
    en = 0;
    do_reset();
    p0v = 1;
    p1r = 1;
    for (int k = 0; k < 20; k++) begin p0 = 16'($urandom); tick(); end
    lit("dis_wr", dut_wr, 0);
    lit("dis_rd", dut_rd, 0);
    en = 1;
    set_cfg();
    for (int k = 0; k < 30; k++) begin p0 = 16'($urandom); tick(); end
    lit("en_wr", dut_wr, 30);
    lit("en_rd", dut_rd, 29);
    // randomized configurations
    for (int c = 0; c < 16; c++) begin
      en = 1;
      wd = $urandom % 4;
      rdm = $urandom % 4;
      for (int i = 0; i < 3; i++) begin
        we[i] = $urandom % 6;
        re[i] = $urandom % 6;
        ws[i] = int'($urandom % 17) - 8;
        rs[i] = int'($urandom % 17) - 8;
      end
      wo = $urandom % 65536;
      ro = $urandom % 65536;
      ahead = $urandom % 21;
      gap = $urandom % 7;
      do_reset();
      for (int k = 0; k < 150; k++) begin
        p0v = ($urandom % 4) != 0;
        p1r = ($urandom % 4) != 0;
        p0 = 16'($urandom);
        flush = ($urandom % 50) == 0;
        tick();
      end
      flush = 0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lake_spec.md
# lake_spec

Configurable, latency-insensitive on-chip buffer: one write stream (port_0) stores data into a local memory and one read stream (port_1) reads it back, each driven by its own bitstream-programmed affine address generator. All behaviour comes from a static configuration vector that is held constant during operation. The buffer sits between streaming producers and consumers in the accelerator fabric, and a dependency check keeps the writer from overrunning the reader.

## Interface
- DATA_WIDTH, 16, data word width
- MEM_DEPTH, 64, storage words (power of two); addresses use the low log2(MEM_DEPTH) bits
- CONFIG_MEMORY_SIZE, 512, configuration vector width (≥261)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active-high (1 = reset), as named in codebase
- flush  in  1  synchronous restart; 1 = return iterators to start
- config_memory  in  CONFIG_MEMORY_SIZE  static configuration, fields below
- port_0  in  DATA_WIDTH  write data
- port_0_valid  in  1  write data valid
- port_0_ready  out  1  buffer accepts write
- port_1  out  DATA_WIDTH  read data
- port_1_valid  out  1  read data valid
- port_1_ready  in  1  consumer accepts read

## Operation
- Config fields, with bit 0 as LSB: [0] enable; [2:1] wr_dims; [50:3] wr_extent[0..2] (16 b each, dim0 at LSB); [98:51] wr_stride[0..2] (signed 16 b); [114:99] wr_offset; [116:115] rd_dims; [164:117] rd_extent[0..2]; [212:165] rd_stride[0..2]; [228:213] rd_offset; [244:229] ahead_limit; [260:245] min_gap. Bits above 260 are ignored.
- Dims value 0 is treated as 1; values above 3 clamp to 3. Extent 0 is treated as 1. Unused dims have extent 1.
- Each generator is a nested loop with dim0 innermost. addr = offset + Σ idx_i·stride_i, computed in 16-bit two's complement and truncated to log2(MEM_DEPTH) bits, so it wraps modulo MEM_DEPTH.
- Each port has a total iteration count of Π extent. After the last transfer the port is done: its ready/valid output stays 0 until flush or reset.
- wr_cnt and rd_cnt are 32-bit counters of completed transfers.
- port_0_ready = enable & ~wr_done & ((wr_cnt − rd_cnt) < ahead_limit).
- port_1_valid = enable & ~rd_done & (((wr_cnt − rd_cnt) ≥ max(min_gap,1)) | wr_done).
- Write fire (port_0_valid & port_0_ready): mem[wr_addr] ← port_0, then the write iterator and wr_cnt advance.
- Read fire (port_1_valid & port_1_ready): the read iterator and rd_cnt advance.
- port_1 = mem[rd_addr] combinationally when port_1_valid = 1; otherwise port_1 = 0.
- Simultaneous write and read fire in one cycle are both performed, and both counters update. Dependency checks use pre-edge counter values.
- enable = 0: both handshake outputs are 0 and no state changes.
- Flush: iterators, counters and done flags return to start values; memory contents are preserved. Flush overrides any fire in the same cycle.

## Timing
- Reset asserted: port_0_ready = 0, port_1_valid = 0, port_1 = 0; iterators, counters and done flags are cleared. Memory is not reset.
- Reset deassertion mid-stream restarts the stream from iteration 0.
- port_0_ready, port_1_valid and port_1 depend only on registered state and config_memory. There is no combinational path from port_0_valid or port_1_ready.
- Write-to-read latency is 1 cycle: a word written at edge k can appear on port_1 after edge k, provided min_gap is satisfied.
- Throughput is 1 write and 1 read per cycle at steady state.
- A write to the address currently being read is safe, because min_gap ≥ 1 guarantees that location was written at an earlier count.

## Test plan
- Linear FIFO-like backpressure: 1-D, extents 1000, strides 1, offsets 0, ahead_limit 64, min_gap 1, port_0_valid held 1, data 2·cycle, port_1_ready held 0 for 65 cycles. Exactly 64 writes are accepted, then port_0_ready = 0; port_1_valid = 1 with port_1 = 0.
- Same stream, port_1_ready raised: reads 0, 2, 4, … in order at one per cycle with no gaps; writes resume one per cycle; modulo-64 wrap is transparent.
- 2-D transpose: write extents 4×4 with strides 1, 4; read strides 4, 1; ahead_limit 16; min_gap 16; input 0..15. Output is 0, 4, 8, 12, 1, 5, …, 15.
- Completion: extents 8 for both ports. After the 8th write port_0_ready = 0 permanently; after the 8th read port_1_valid = 0. Flush restarts both ports, and the next 8 writes are accepted.
- Reset mid-stream: assert rst_n after 10 writes. All outputs go to 0 immediately (asynchronously). After release the first write targets wr_offset.
- enable = 0 with valid/ready both high: no handshake is ever asserted, and counters stay at 0.
